tag_prefetch_queue: RTL and testbench
=====================================

TAG_PREFETCH_QUEUE -- requirements
Module: tag_prefetch_queue

Interface
REQ-001 SHALL have parameters: NUM_UOPS, default 4, lanes per cycle; DEPTH, default 16, queue entries (power of two, at least 2*NUM_UOPS).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port IN_mispr, input, 1, mispredict; flush.
REQ-005 SHALL have port IN_issueTags, input, NUM_UOPS*6, free tags offered by the tag allocator.
REQ-006 SHALL have port IN_issueTagsValid, input, NUM_UOPS, offered-tag valid per lane.
REQ-007 SHALL have port OUT_issueValid, output, NUM_UOPS, claim per lane; allocator marks the claimed tag used.
REQ-008 SHALL have port IN_renameReq, input, NUM_UOPS, rename-stage tag request per lane.
REQ-009 SHALL have port OUT_renameTags, output, NUM_UOPS*6, tag delivered per lane.
REQ-010 SHALL have port OUT_renameValid, output, NUM_UOPS, lane i valid iff count > i.
REQ-011 SHALL have port OUT_renameStall, output, 1, popcount(IN_renameReq) > count.
REQ-012 SHALL have port OUT_count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-013 SHALL hold tags in a circular buffer with read ptr, write ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count.
REQ-014 SHALL compute claim count K = number of leading (prefix) lanes with IN_issueTagsValid set, capped at DEPTH - count (current cycle, dequeues ignored); OUT_issueValid[i] = (i < K) and !IN_mispr.
REQ-015 SHALL write claimed lane i tag to entry wr+i; wr += K; takes effect next cycle (1-cycle latency to OUT_renameTags).
REQ-016 SHALL give requesting lane i the tag at rd + rank(i), rank(i) = number of requested lanes below i; OUT_renameTags of non-requesting lanes SHALL equal entry rd+i.
REQ-017 SHALL dequeue R = popcount(IN_renameReq) entries (rd += R) only when !OUT_renameStall and !IN_mispr; a stall dequeues nothing (all-or-nothing).
REQ-018 SHALL update count = count + K - R in the same cycle when both occur; full and empty never over/underflow.
REQ-019 SHALL, on IN_mispr, set rd = wr = count = 0 next cycle, with no claim and no dequeue that cycle (allocator reclaims all uncommitted tags, including queued ones).
REQ-020 SHALL drive OUT_renameTags, OUT_renameValid and OUT_count from registered state only; OUT_renameStall and OUT_issueValid are combinational from inputs plus state.
REQ-021 SHALL assert OUT_renameStall when empty with any request, and never assert it when IN_renameReq == 0.

Reset
REQ-022 SHALL, on rst low (asynchronous), clear rd, wr and count to 0, giving OUT_count = 0, OUT_renameValid = 0, OUT_issueValid = 0; tag storage need not be reset.
REQ-023 SHALL, on reset mid-operation, discard all queued tags; the allocator is reset concurrently.

Structure
REQ-024 SHALL take TAG_W = 6, NUM_UOPS and TQ_DEPTH from the shared package tag_pkg.
REQ-025 SHALL compute prefix count and per-lane rank in one sub-module, lane_rank (NUM_UOPS-wide mask in, popcount and ranks out).

Verification
REQ-026 SHALL cover fill: empty, 4 valid offers of tags 0x3F,0x3E,0x3D,0x3C -> OUT_issueValid = 4'b1111; next cycle OUT_count = 4, OUT_renameTags = 0x3F,0x3E,0x3D,0x3C.
REQ-027 SHALL cover full: count = 14, 4 offers -> OUT_issueValid = 4'b0011; count becomes 16; next cycle 4 offers -> OUT_issueValid = 0.
REQ-028 SHALL cover stall: count = 2, IN_renameReq = 4'b0111 -> OUT_renameStall = 1, count stays 2; IN_renameReq = 4'b0101 -> lane 0 gets head, lane 2 gets head+1, count becomes 0.
REQ-029 SHALL cover simultaneous enqueue and dequeue: count = 5, K = 3, R = 2 -> count 6; wr and rd wrap correctly across entry 15 to 0.
REQ-030 SHALL cover mispredict: count = 9, IN_mispr with offers and requests -> OUT_issueValid = 0, no dequeue; next cycle count = 0, OUT_renameValid = 0.
REQ-031 SHALL cover reset mid-stream: rst low asynchronously between edges -> OUT_count = 0 immediately; after release, the first claim is written to entry 0.

Source files
------------

// File: rtl/tag_pkg.sv
// Shared sizing for the rename-tag prefetch path: tag width, lane count and queue depth.
package tag_pkg;

    localparam int TAG_W    = 6;
    localparam int NUM_UOPS = 4;
    localparam int TQ_DEPTH = 16;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/tag_prefetch_queue_lane_rank.sv
// Per-lane mask statistics: total set lanes, length of the leading run of set
// lanes, and for each lane the number of set lanes strictly below it.
module lane_rank #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]    mask,
    output logic [CW-1:0]   popcount,
    output logic [CW-1:0]   prefix,
    output logic [N*CW-1:0] ranks
);

    // Single ripple pass: rank is the running count before the lane is added.
    always_comb begin
        logic [CW-1:0] acc_s;
        logic          run_s;
        acc_s  = '0;
        run_s  = 1'b1;
        prefix = '0;
        ranks  = '0;
        for (int i = 0; i < N; i++) begin
            ranks[i*CW +: CW] = acc_s;
            if (mask[i]) begin
                acc_s = acc_s + CW'(1);
            end else begin
                acc_s = acc_s;
            end
            if (run_s && mask[i]) begin
                prefix = prefix + CW'(1);
            end else begin
                run_s = 1'b0;
            end
        end
        popcount = acc_s;
    end

endmodule

// File: rtl/tag_prefetch_queue.sv
// Circular buffer that pre-claims free tags from the allocator so rename can
// take up to NUM_UOPS tags per cycle without waiting on the allocator search.
module tag_prefetch_queue
    import tag_pkg::*;
#(
    parameter int NUM_UOPS = tag_pkg::NUM_UOPS,
    parameter int DEPTH    = TQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_mispr,
    input  logic [NUM_UOPS*TAG_W-1:0] IN_issueTags,
    input  logic [NUM_UOPS-1:0]       IN_issueTagsValid,
    output logic [NUM_UOPS-1:0]       OUT_issueValid,
    input  logic [NUM_UOPS-1:0]       IN_renameReq,
    output logic [NUM_UOPS*TAG_W-1:0] OUT_renameTags,
    output logic [NUM_UOPS-1:0]       OUT_renameValid,
    output logic                      OUT_renameStall,
    output logic [$clog2(DEPTH):0]    OUT_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(NUM_UOPS + 1);

    logic [TAG_W-1:0]      mem_r [DEPTH];
    logic [PW-1:0]         rd_r;
    logic [PW-1:0]         wr_r;
    logic [CW-1:0]         count_r;

    logic [LW-1:0]         issue_pop_s;
    logic [LW-1:0]         issue_prefix_s;
    logic [NUM_UOPS*LW-1:0] issue_ranks_s;
    logic [LW-1:0]         req_pop_s;
    logic [LW-1:0]         req_prefix_s;
    logic [NUM_UOPS*LW-1:0] req_ranks_s;

    logic [CW-1:0]         free_s;
    logic [CW-1:0]         claim_s;
    logic [CW-1:0]         claim_eff_s;
    logic [CW-1:0]         req_cnt_s;
    logic [CW-1:0]         deq_cnt_s;
    logic                  stall_s;
    logic [NUM_UOPS-1:0]   issue_valid_s;
    logic                  unused_s;

    lane_rank #(.N(NUM_UOPS), .CW(LW)) u_issue_rank (
        .mask     (IN_issueTagsValid),
        .popcount (issue_pop_s),
        .prefix   (issue_prefix_s),
        .ranks    (issue_ranks_s)
    );

    lane_rank #(.N(NUM_UOPS), .CW(LW)) u_req_rank (
        .mask     (IN_renameReq),
        .popcount (req_pop_s),
        .prefix   (req_prefix_s),
        .ranks    (req_ranks_s)
    );

    assign unused_s = ^{issue_pop_s, issue_ranks_s, req_prefix_s};

    // Claim only a leading run of offers, limited by the space left this cycle.
    always_comb begin
        free_s  = CW'(DEPTH) - count_r;
        if (CW'(issue_prefix_s) > free_s) begin
            claim_s = free_s;
        end else begin
            claim_s = CW'(issue_prefix_s);
        end
        issue_valid_s = '0;
        for (int i = 0; i < NUM_UOPS; i++) begin
            if ((CW'(i) < claim_s) && !IN_mispr && rst) begin
                issue_valid_s[i] = 1'b1;
            end else begin
                issue_valid_s[i] = 1'b0;
            end
        end
    end

    // Dequeue is all-or-nothing: a partial grant would split a rename group.
    always_comb begin
        req_cnt_s = CW'(req_pop_s);
        stall_s   = (req_cnt_s > count_r);
        if (!stall_s && !IN_mispr) begin
            deq_cnt_s = req_cnt_s;
        end else begin
            deq_cnt_s = '0;
        end
        if (IN_mispr) begin
            claim_eff_s = '0;
        end else begin
            claim_eff_s = claim_s;
        end
    end

    // Pointer and occupancy state; a mispredict empties the queue because the
    // allocator reclaims every uncommitted tag, queued ones included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_r    <= '0;
            wr_r    <= '0;
            count_r <= '0;
        end else if (IN_mispr) begin
            rd_r    <= '0;
            wr_r    <= '0;
            count_r <= '0;
        end else begin
            rd_r    <= rd_r + PW'(deq_cnt_s);
            wr_r    <= wr_r + PW'(claim_eff_s);
            count_r <= count_r + claim_eff_s - deq_cnt_s;
        end
    end

    // Tag storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UOPS; i++) begin
            if (issue_valid_s[i]) begin
                mem_r[wr_r + PW'(i)] <= IN_issueTags[i*TAG_W +: TAG_W];
            end
        end
    end

    // Delivered tags come from storage only, never bypassed from this cycle's offers.
    always_comb begin
        logic [LW-1:0] sel_s;
        sel_s          = '0;
        OUT_renameTags = '0;
        for (int i = 0; i < NUM_UOPS; i++) begin
            if (IN_renameReq[i]) begin
                sel_s = req_ranks_s[i*LW +: LW];
            end else begin
                sel_s = LW'(i);
            end
            OUT_renameTags[i*TAG_W +: TAG_W] = mem_r[rd_r + PW'(sel_s)];
        end
    end

    // Per-lane valid follows occupancy.
    always_comb begin
        OUT_renameValid = '0;
        for (int i = 0; i < NUM_UOPS; i++) begin
            if (count_r > CW'(i)) begin
                OUT_renameValid[i] = 1'b1;
            end else begin
                OUT_renameValid[i] = 1'b0;
            end
        end
    end

    assign OUT_issueValid  = issue_valid_s;
    assign OUT_renameStall = stall_s;
    assign OUT_count       = count_r;

endmodule

// File: tb/tb_tag_prefetch_queue.sv
// Directed scoreboard bench for tag_prefetch_queue: stimulus pushes expected
// observations tagged with a cycle number, a negedge monitor pops and compares.
module tb_tag_prefetch_queue;

    localparam int S_CNT = 0;
    localparam int S_IV  = 1;
    localparam int S_RV  = 2;
    localparam int S_ST  = 3;
    localparam int S_TAG = 4;

    typedef struct {
        string       name;
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_mispr;
    logic [23:0] IN_issueTags;
    logic [3:0]  IN_issueTagsValid;
    logic [3:0]  OUT_issueValid;
    logic [3:0]  IN_renameReq;
    logic [23:0] OUT_renameTags;
    logic [3:0]  OUT_renameValid;
    logic        OUT_renameStall;
    logic [4:0]  OUT_count;

    exp_t        sb[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] obs;

    tag_prefetch_queue #(.NUM_UOPS(4), .DEPTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .IN_mispr          (IN_mispr),
        .IN_issueTags      (IN_issueTags),
        .IN_issueTagsValid (IN_issueTagsValid),
        .OUT_issueValid    (OUT_issueValid),
        .IN_renameReq      (IN_renameReq),
        .OUT_renameTags    (OUT_renameTags),
        .OUT_renameValid   (OUT_renameValid),
        .OUT_renameStall   (OUT_renameStall),
        .OUT_count         (OUT_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pk(input logic [5:0] a, input logic [5:0] b,
                                       input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_CNT:   return {27'd0, OUT_count};
            S_IV:    return {28'd0, OUT_issueValid};
            S_RV:    return {28'd0, OUT_renameValid};
            S_ST:    return {31'd0, OUT_renameStall};
            S_TAG:   return {8'd0, OUT_renameTags};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic ck(input string nm, input int dly, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic drv(input logic [3:0] vld, input logic [23:0] tags,
                       input logic [3:0] req, input logic mis);
        IN_issueTagsValid = vld;
        IN_issueTags      = tags;
        IN_renameReq      = req;
        IN_mispr          = mis;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    obs = observe(sb[i].sel);
                    n_cmp++;
                    if (sb[i].cyc < cyc || obs !== sb[i].val) begin
                        n_bad++;
                        $display("FAIL %s: got %h expected %h (cycle %0d)",
                                 sb[i].name, obs, sb[i].val, cyc);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        drv(4'b1111, pk(6'h01, 6'h02, 6'h03, 6'h04), 4'b0000, 1'b0);
        tick;
        ck("rst_count", 0, S_CNT, 32'd0);
        ck("rst_rvalid", 0, S_RV, 32'd0);
        ck("rst_ivalid", 0, S_IV, 32'd0);
        tick;
        rst = 1'b1;
        drv(4'b0000, 24'd0, 4'b0000, 1'b0);

        // fill from empty
        tick;
        drv(4'b1111, pk(6'h3F, 6'h3E, 6'h3D, 6'h3C), 4'b0000, 1'b0);
        ck("fill_iv", 0, S_IV, 32'hF);
        ck("fill_stall", 0, S_ST, 32'd0);
        ck("fill_cnt", 1, S_CNT, 32'd4);
        ck("fill_rv", 1, S_RV, 32'hF);
        ck("fill_tags", 1, S_TAG, {8'd0, pk(6'h3F, 6'h3E, 6'h3D, 6'h3C)});
        tick;
        drv(4'b1111, pk(6'h01, 6'h02, 6'h03, 6'h04), 4'b0000, 1'b0);
        tick;
        drv(4'b1111, pk(6'h05, 6'h06, 6'h07, 6'h08), 4'b0000, 1'b0);
        ck("cnt8", 0, S_CNT, 32'd8);
        tick;
        drv(4'b1011, pk(6'h09, 6'h0A, 6'h3F, 6'h0B), 4'b0000, 1'b0);
        ck("prefix_iv", 0, S_IV, 32'h3);
        ck("cnt14", 1, S_CNT, 32'd14);

        // near full and full
        tick;
        drv(4'b1111, pk(6'h10, 6'h11, 6'h12, 6'h13), 4'b0000, 1'b0);
        ck("full_cap_iv", 0, S_IV, 32'h3);
        ck("full_cnt", 1, S_CNT, 32'd16);
        tick;
        drv(4'b1111, pk(6'h14, 6'h15, 6'h16, 6'h17), 4'b0000, 1'b0);
        ck("full_iv", 0, S_IV, 32'h0);
        ck("full_hold", 1, S_CNT, 32'd16);

        // drain
        tick;
        drv(4'b0000, 24'd0, 4'b1111, 1'b0);
        ck("drain0_tags", 0, S_TAG, {8'd0, pk(6'h3F, 6'h3E, 6'h3D, 6'h3C)});
        ck("drain0_stall", 0, S_ST, 32'd0);
        ck("drain0_cnt", 1, S_CNT, 32'd12);
        tick;
        ck("drain1_tags", 0, S_TAG, {8'd0, pk(6'h01, 6'h02, 6'h03, 6'h04)});
        tick;
        ck("drain2_tags", 0, S_TAG, {8'd0, pk(6'h05, 6'h06, 6'h07, 6'h08)});
        tick;
        drv(4'b0000, 24'd0, 4'b0011, 1'b0);
        ck("drain3_tags", 0, S_TAG, {8'd0, pk(6'h09, 6'h0A, 6'h10, 6'h11)});
        ck("drain3_cnt", 1, S_CNT, 32'd2);

        // stall then sparse request
        tick;
        drv(4'b0000, 24'd0, 4'b0111, 1'b0);
        ck("stall_st", 0, S_ST, 32'd1);
        ck("stall_rv", 0, S_RV, 32'h3);
        ck("stall_cnt", 1, S_CNT, 32'd2);
        tick;
        drv(4'b0000, 24'd0, 4'b0101, 1'b0);
        ck("sparse_st", 0, S_ST, 32'd0);
        ck("sparse_tags", 0, S_TAG, {8'd0, pk(6'h10, 6'h11, 6'h11, 6'h3E)});
        ck("sparse_cnt", 1, S_CNT, 32'd0);
        tick;
        drv(4'b0000, 24'd0, 4'b0001, 1'b0);
        ck("empty_st", 0, S_ST, 32'd1);
        ck("empty_rv", 0, S_RV, 32'd0);

        // simultaneous enqueue/dequeue with pointer wrap
        tick;
        drv(4'b1111, pk(6'h20, 6'h21, 6'h22, 6'h23), 4'b0000, 1'b0);
        ck("idle_st", 0, S_ST, 32'd0);
        tick;
        drv(4'b1111, pk(6'h24, 6'h25, 6'h26, 6'h27), 4'b0000, 1'b0);
        tick;
        drv(4'b1111, pk(6'h28, 6'h29, 6'h2A, 6'h2B), 4'b1111, 1'b0);
        ck("both0_iv", 0, S_IV, 32'hF);
        ck("both0_tags", 0, S_TAG, {8'd0, pk(6'h20, 6'h21, 6'h22, 6'h23)});
        ck("both0_cnt", 1, S_CNT, 32'd8);
        tick;
        drv(4'b0001, pk(6'h2C, 6'h00, 6'h00, 6'h00), 4'b1111, 1'b0);
        ck("both1_tags", 0, S_TAG, {8'd0, pk(6'h24, 6'h25, 6'h26, 6'h27)});
        ck("both1_cnt", 1, S_CNT, 32'd5);
        tick;
        drv(4'b0111, pk(6'h2D, 6'h2E, 6'h2F, 6'h00), 4'b0011, 1'b0);
        ck("k3r2_iv", 0, S_IV, 32'h7);
        ck("k3r2_tags", 0, S_TAG, {8'd0, pk(6'h28, 6'h29, 6'h2A, 6'h2B)});
        ck("k3r2_cnt", 1, S_CNT, 32'd6);
        tick;
        drv(4'b0001, pk(6'h30, 6'h00, 6'h00, 6'h00), 4'b1111, 1'b0);
        ck("wrap_w_tags", 0, S_TAG, {8'd0, pk(6'h2A, 6'h2B, 6'h2C, 6'h2D)});
        ck("wrap_w_cnt", 1, S_CNT, 32'd3);
        tick;
        drv(4'b0000, 24'd0, 4'b0111, 1'b0);
        ck("wrap_r_tags", 0, S_TAG, {8'd0, pk(6'h2E, 6'h2F, 6'h30, 6'h21)});
        ck("wrap_r_cnt", 1, S_CNT, 32'd0);

        // mispredict flush at count 9
        tick;
        drv(4'b1111, pk(6'h31, 6'h32, 6'h33, 6'h34), 4'b0000, 1'b0);
        tick;
        drv(4'b1111, pk(6'h35, 6'h36, 6'h37, 6'h38), 4'b0000, 1'b0);
        tick;
        drv(4'b0001, pk(6'h39, 6'h00, 6'h00, 6'h00), 4'b0000, 1'b0);
        tick;
        drv(4'b1111, pk(6'h01, 6'h02, 6'h03, 6'h04), 4'b0011, 1'b1);
        ck("mis_pre_cnt", 0, S_CNT, 32'd9);
        ck("mis_iv", 0, S_IV, 32'd0);
        ck("mis_cnt", 1, S_CNT, 32'd0);
        ck("mis_rv", 1, S_RV, 32'd0);
        tick;
        drv(4'b0001, pk(6'h15, 6'h00, 6'h00, 6'h00), 4'b0000, 1'b0);
        ck("post_mis_iv", 0, S_IV, 32'h1);
        ck("post_mis_tags", 1, S_TAG, {8'd0, pk(6'h15, 6'h31, 6'h32, 6'h33)});
        ck("post_mis_rv", 1, S_RV, 32'h1);
        tick;
        drv(4'b0011, pk(6'h01, 6'h02, 6'h00, 6'h00), 4'b0000, 1'b0);
        ck("pre_rst_cnt", 1, S_CNT, 32'd3);
        tick;
        drv(4'b0000, 24'd0, 4'b0000, 1'b0);

        // asynchronous reset between edges
        tick;
        drv(4'b1111, pk(6'h01, 6'h02, 6'h03, 6'h04), 4'b0000, 1'b0);
        #1;
        rst = 1'b0;
        ck("async_cnt", 0, S_CNT, 32'd0);
        ck("async_rv", 0, S_RV, 32'd0);
        ck("async_iv", 0, S_IV, 32'd0);
        tick;
        rst = 1'b1;
        drv(4'b0001, pk(6'h2A, 6'h00, 6'h00, 6'h00), 4'b0000, 1'b0);
        ck("rel_iv", 0, S_IV, 32'h1);
        ck("rel_cnt", 0, S_CNT, 32'd0);
        ck("rel_tags", 1, S_TAG, {8'd0, pk(6'h2A, 6'h01, 6'h02, 6'h33)});
        ck("rel_next_cnt", 1, S_CNT, 32'd1);
        tick;
        drv(4'b0000, 24'd0, 4'b0000, 1'b0);
        tick;
        tick;

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
